// File: rtl/pmod_dac_spi_tx.sv
// pmod_dac_spi_tx: buffered mode-0 SPI transmitter for the PMOD DAC.
// 16-bit codes arrive over valid/ready and are queued in a 2^FIFO_AW-entry FIFO.
// Each code is sent MSB first, then an LDAC pulse latches it onto the DAC output.
// All outputs are registered. The flops take the value computed for the next state,
// so each output lines up with the state that owns it.
// Optional build macro PMOD_DAC_LDAC_HOLD_EN: also drive dac_ldac_n low in CS_HI,
// so the DAC loads directly on the rising edge of dac_cs_n.
module pmod_dac_spi_tx #(
    parameter int unsigned FIFO_AW    = 2,
    parameter int unsigned LDAC_WIDTH = 2,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic               slow_clk,
    input  logic               rst,
    input  logic [15:0]        s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               dac_cs_n,
    output logic               dac_ldac_n,
    output logic               dac_sclk,
    output logic               dac_din,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [15:0]        frame_count
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CS_HI = 3'd3,
        ST_LDAC  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        shreg_q, shreg_d;
    logic [4:0]         edge_cnt_q, edge_cnt_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               cs_n_q, cs_n_d;
    logic               ldac_n_q, ldac_n_d;
    logic               sclk_q, sclk_d;
    logic               din_q, din_d;
    logic               busy_q, busy_d;
    logic               s_ready_q, s_ready_d;

    logic [15:0]        mem_q [DEPTH];
    logic [15:0]        mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               push;
    logic               pop;

    // FIFO bookkeeping: push on handshake, pop when the FSM takes a code in IDLE
    always_comb begin
        push     = s_valid && s_ready_q;
        pop      = (state_q == ST_IDLE) && (level_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_data;
            wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
            2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
            default: level_d = level_q;
        endcase
        // Ready follows the level that the flops will hold after this edge.
        s_ready_d = (level_d < (FIFO_AW + 1)'(DEPTH));
    end

    // Next-state and next-output logic; every line defaults to its idle level
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        edge_cnt_d    = edge_cnt_q;
        cnt_d         = cnt_q;
        frame_count_d = frame_count_q;
        cs_n_d        = 1'b1;
        ldac_n_d      = 1'b1;
        sclk_d        = 1'b0;
        din_d         = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    shreg_d    = mem_q[rd_ptr_q];
                    edge_cnt_d = '0;
                    state_d    = ST_SETUP;
                    cs_n_d     = 1'b0;
                    din_d      = mem_q[rd_ptr_q][15];
                end
            end

            ST_SETUP: begin
                // First SHIFT cycle is a rising edge of dac_sclk.
                state_d    = ST_SHIFT;
                cs_n_d     = 1'b0;
                sclk_d     = 1'b1;
                din_d      = shreg_q[15];
                edge_cnt_d = edge_cnt_q + 5'd1;
            end

            ST_SHIFT: begin
                if (!sclk_q && (edge_cnt_q == 5'd16)) begin
                    // 16 rising and 16 falling edges done: release chip select.
                    state_d = ST_CS_HI;
`ifdef PMOD_DAC_LDAC_HOLD_EN
                    ldac_n_d = 1'b0;
`endif
                end else if (sclk_q) begin
                    // Falling edge: advance to the next bit.
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    shreg_d = {shreg_q[14:0], 1'b0};
                    din_d   = shreg_q[14];
                end else begin
                    // Rising edge: data already stable from the previous falling edge.
                    cs_n_d     = 1'b0;
                    sclk_d     = 1'b1;
                    din_d      = shreg_q[15];
                    edge_cnt_d = edge_cnt_q + 5'd1;
                end
            end

            ST_CS_HI: begin
                state_d  = ST_LDAC;
                ldac_n_d = 1'b0;
                cnt_d    = '0;
            end

            ST_LDAC: begin
                if (cnt_q == 8'(LDAC_WIDTH - 1)) begin
                    state_d       = ST_GAP;
                    cnt_d         = '0;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    ldac_n_d = 1'b0;
                    cnt_d    = cnt_q + 8'd1;
                end
            end

            ST_GAP: begin
                if (cnt_q == 8'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            edge_cnt_q    <= '0;
            cnt_q         <= '0;
            frame_count_q <= '0;
            cs_n_q        <= 1'b1;
            ldac_n_q      <= 1'b1;
            sclk_q        <= 1'b0;
            din_q         <= 1'b1;
            busy_q        <= 1'b0;
            s_ready_q     <= 1'b1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            edge_cnt_q    <= edge_cnt_d;
            cnt_q         <= cnt_d;
            frame_count_q <= frame_count_d;
            cs_n_q        <= cs_n_d;
            ldac_n_q      <= ldac_n_d;
            sclk_q        <= sclk_d;
            din_q         <= din_d;
            busy_q        <= busy_d;
            s_ready_q     <= s_ready_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
        end
    end

    // FIFO storage; reset flushes through the pointers, so no reset is needed here
    always_ff @(posedge slow_clk) begin
        mem_q <= mem_d;
    end

    assign s_ready     = s_ready_q;
    assign dac_cs_n    = cs_n_q;
    assign dac_ldac_n  = ldac_n_q;
    assign dac_sclk    = sclk_q;
    assign dac_din     = din_q;
    assign busy        = busy_q;
    assign fifo_level  = level_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pmod_dac_spi_tx.sv
// Self-checking bench for pmod_dac_spi_tx.
// The monitor rebuilds each SPI frame from dac_din sampled on dac_sclk rising edges.
// It compares each frame against a queue of codes that were accepted on the input.
`timescale 1ns/1ps
module tb_pmod_dac_spi_tx;

    localparam int unsigned FIFO_AW    = 2;
    localparam int unsigned LDAC_WIDTH = 2;
    localparam int unsigned GAP_CYCLES = 4;
    localparam int unsigned DEPTH      = 4;
    localparam int          PERIOD     = 1 + 1 + 32 + 1 + LDAC_WIDTH + GAP_CYCLES;
    localparam int          LIMIT      = 600;
`ifdef PMOD_DAC_LDAC_HOLD_EN
    localparam int          LDAC_LOW        = LDAC_WIDTH + 1;
    localparam logic        LDAC_AT_CS_RISE = 1'b0;
`else
    localparam int          LDAC_LOW        = LDAC_WIDTH;
    localparam logic        LDAC_AT_CS_RISE = 1'b1;
`endif

    logic               slow_clk = 1'b0;
    logic               rst = 1'b1;
    logic [15:0]        s_data = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic               dac_cs_n, dac_ldac_n, dac_sclk, dac_din, busy;
    logic [FIFO_AW:0]   fifo_level;
    logic [15:0]        frame_count;

    pmod_dac_spi_tx #(
        .FIFO_AW   (FIFO_AW),
        .LDAC_WIDTH(LDAC_WIDTH),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .slow_clk   (slow_clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .dac_cs_n   (dac_cs_n),
        .dac_ldac_n (dac_ldac_n),
        .dac_sclk   (dac_sclk),
        .dac_din    (dac_din),
        .busy       (busy),
        .fifo_level (fifo_level),
        .frame_count(frame_count)
    );

    always #100 slow_clk = ~slow_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge slow_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Scoreboard and monitor state
    logic [15:0] sb_q[$];
    int          fall_cyc[$];
    logic [15:0] rx_word = '0;
    logic [15:0] last_word = '0;
    int          rx_bits = 0;
    int          ldac_len = 0;
    int          ldac_pulses = 0;
    logic [15:0] frames_done = '0;
    logic [15:0] frame_offset = '0;
    bit          in_frame = 1'b0;
    logic        prev_sclk = 1'b0;
    logic        prev_cs_n = 1'b1;
    logic        prev_ldac = 1'b1;

    // Monitor: sample on the falling slow_clk edge, away from the DUT's update edge
    always @(negedge slow_clk) begin
        logic [15:0] exp_code;
        if (rst) begin
            rx_bits     = 0;
            ldac_len    = 0;
            in_frame    = 1'b0;
            frames_done = '0;
        end else begin
            if (prev_cs_n && !dac_cs_n) begin
                fall_cyc.push_back(cyc);
                rx_bits  = 0;
                rx_word  = '0;
                in_frame = 1'b1;
            end
            if (!dac_cs_n && dac_sclk && !prev_sclk) begin
                rx_word = {rx_word[14:0], dac_din};
                rx_bits++;
            end
            if (dac_cs_n) begin
                check("idle_lines", 32'({dac_sclk, dac_din}), 32'd1);
            end
            if (!prev_cs_n && dac_cs_n && in_frame) begin
                in_frame = 1'b0;
                check("frame_bits", 32'(rx_bits), 32'd16);
                check("ldac_at_cs_rise", 32'(dac_ldac_n), 32'(LDAC_AT_CS_RISE));
                if (sb_q.size() == 0) begin
                    timeout("scoreboard_empty");
                end else begin
                    exp_code = sb_q.pop_front();
                    check("frame_data", 32'(rx_word), 32'(exp_code));
                end
                last_word   = rx_word;
                frames_done = frames_done + 16'd1;
            end
            if (!dac_ldac_n) ldac_len++;
            if (!prev_ldac && dac_ldac_n) begin
                ldac_pulses++;
                check("ldac_width", 32'(ldac_len), 32'(LDAC_LOW));
                check("frame_count", 32'(frame_count), 32'(16'(frames_done + frame_offset)));
                ldac_len = 0;
            end
            check("s_ready_vs_level", 32'(s_ready), 32'(fifo_level < (FIFO_AW + 1)'(DEPTH)));
        end
        prev_sclk = dac_sclk;
        prev_cs_n = dac_cs_n;
        prev_ldac = dac_ldac_n;
    end

    task automatic check_reset(input string tag);
        check({tag, "_cs_n"},        32'(dac_cs_n),    32'd1);
        check({tag, "_ldac_n"},      32'(dac_ldac_n),  32'd1);
        check({tag, "_sclk"},        32'(dac_sclk),    32'd0);
        check({tag, "_din"},         32'(dac_din),     32'd1);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_s_ready"},     32'(s_ready),     32'd1);
        check({tag, "_fifo_level"},  32'(fifo_level),  32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    // Hold s_valid with the given code until a handshake edge; s_valid is left high
    task automatic push(input logic [15:0] code, output int waited);
        logic rdy;
        waited = 0;
        s_data = code;
        s_valid = 1'b1;
        do begin
            rdy = s_ready;
            @(posedge slow_clk);
            #1;
            waited++;
        end while (!rdy && waited < LIMIT);
        if (!rdy) timeout("push");
        else sb_q.push_back(code);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(busy === 1'b0 && fifo_level == '0) && n < LIMIT) begin
            @(posedge slow_clk);
            #1;
            n++;
        end
        if (n >= LIMIT) timeout("wait_idle");
    endtask

    task automatic wait_pulses(input int target);
        int n = 0;
        while (ldac_pulses < target && n < 8 * PERIOD) begin
            @(posedge slow_clk);
            #1;
            n++;
        end
        if (ldac_pulses < target) timeout("wait_ldac");
    endtask

    typedef struct {
        logic [15:0] code;
        logic [15:0] exp_word;
        logic [15:0] exp_count;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   w;
        int   d;
        int   n0;
        int   p0;
        int   stall;
        int   n;
        int   rises;
        logic prev;

        vecs[0] = '{code: 16'hA5C3, exp_word: 16'b1010_0101_1100_0011, exp_count: 16'd1};
        vecs[1] = '{code: 16'hFFFF, exp_word: 16'hFFFF, exp_count: 16'd2};
        vecs[2] = '{code: 16'h0001, exp_word: 16'h0001, exp_count: 16'd3};
        vecs[3] = '{code: 16'h8000, exp_word: 16'h8000, exp_count: 16'd4};

        // Reset values while rst is held
        repeat (3) @(posedge slow_clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge slow_clk);
        #1;
        check_reset("after_reset");

        // Single frames from idle: latency, bit order, LDAC, frame count
        for (int i = 0; i < 4; i++) begin
            wait_idle();
            d  = cyc;
            n0 = fall_cyc.size();
            p0 = ldac_pulses;
            push(vecs[i].code, w);
            s_valid = 1'b0;
            wait_pulses(p0 + 1);
            if (fall_cyc.size() > n0) check("cs_fall_latency", 32'(fall_cyc[n0] - d), 32'd2);
            else timeout("cs_fall_latency");
            check("vec_word", 32'(last_word), 32'(vecs[i].exp_word));
            check("vec_count", 32'(frame_count), 32'(vecs[i].exp_count));
        end

        // Five codes with s_valid held: queue fills, frames run back to back
        wait_idle();
        n0 = fall_cyc.size();
        p0 = ldac_pulses;
        stall = 0;
        for (int i = 0; i < 5; i++) begin
            push(16'(i * 16'h1000), w);
            stall += w;
        end
        s_valid = 1'b0;
        check("five_push_cycles", 32'(stall), 32'd5);
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_level", 32'(fifo_level), 32'(DEPTH));
        n = 0;
        while (s_ready !== 1'b1 && n < 2 * PERIOD) begin
            @(posedge slow_clk);
            #1;
            n++;
        end
        if (s_ready !== 1'b1) timeout("s_ready_rise");
        check("level_after_pop", 32'(fifo_level), 32'(DEPTH - 1));
        wait_pulses(p0 + 5);
        if (fall_cyc.size() >= n0 + 5) begin
            for (int i = 0; i < 4; i++)
                check("frame_period", 32'(fall_cyc[n0 + i + 1] - fall_cyc[n0 + i]), 32'(PERIOD));
        end else begin
            timeout("frame_period");
        end
        check("five_count", 32'(frame_count), 32'd9);

        // Push and pop in the same cycle with two entries queued
        wait_idle();
        p0 = ldac_pulses;
        push(16'h1357, w);
        s_valid = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(posedge slow_clk);
            #1;
            n++;
        end
        push(16'h2468, w);
        push(16'h369C, w);
        s_valid = 1'b0;
        check("two_queued", 32'(fifo_level), 32'd2);
        n = 0;
        while (busy !== 1'b0 && n < 2 * PERIOD) begin
            @(posedge slow_clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) timeout("idle_slot");
        check("idle_slot_level", 32'(fifo_level), 32'd2);
        check("idle_slot_ready", 32'(s_ready), 32'd1);
        push(16'h4BD2, w);
        s_valid = 1'b0;
        check("push_pop_wait", 32'(w), 32'd1);
        check("push_pop_level", 32'(fifo_level), 32'd2);
        check("push_pop_ready", 32'(s_ready), 32'd1);
        check("push_pop_busy", 32'(busy), 32'd1);
        wait_pulses(p0 + 4);
        check("push_pop_count", 32'(frame_count), 32'd13);

        // frame_count wraps from 0xFFFF to 0
        wait_idle();
        force dut.frame_count_q = 16'hFFFF;
        @(posedge slow_clk);
        @(posedge slow_clk);
        #1;
        release dut.frame_count_q;
        frame_offset = 16'hFFFF - frames_done;
        @(posedge slow_clk);
        #1;
        check("preload_count", 32'(frame_count), 32'h0000_FFFF);
        p0 = ldac_pulses;
        push(16'h5A5A, w);
        s_valid = 1'b0;
        wait_pulses(p0 + 1);
        check("wrap_count", 32'(frame_count), 32'd0);

        // Reset at the 8th dac_sclk rising edge aborts the frame with no LDAC
        wait_idle();
        p0 = ldac_pulses;
        push(16'h1234, w);
        s_valid = 1'b0;
        rises = 0;
        prev = 1'b0;
        n = 0;
        while (rises < 8 && n < 2 * PERIOD) begin
            @(negedge slow_clk);
            n++;
            if (!dac_cs_n && dac_sclk && !prev) rises++;
            prev = dac_sclk;
        end
        if (rises < 8) timeout("eighth_rise");
        #1;
        rst = 1'b1;
        #1;
        check_reset("mid_frame_reset");
        sb_q.delete();
        frame_offset = '0;
        @(posedge slow_clk);
        #1;
        @(posedge slow_clk);
        #1;
        rst = 1'b0;
        repeat (3 * PERIOD) @(posedge slow_clk);
        #1;
        check("no_ldac_after_abort", 32'(ldac_pulses), 32'(p0));
        check("abort_busy", 32'(busy), 32'd0);
        push(16'hFFFF, w);
        s_valid = 1'b0;
        wait_pulses(p0 + 1);
        check("post_reset_word", 32'(last_word), 32'h0000_FFFF);
        check("post_reset_count", 32'(frame_count), 32'd1);

        repeat (5) @(posedge slow_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #40_000_000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d failures=%0d)", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
